// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the buffered 1-to-N stream demultiplexer.
// Imported by the per-channel FIFO and the demux top.
package stream_demux_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo2_state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO; the head register drives pop_data directly.
// push_ready depends only on state, so there is no pop_ready -> push_ready path.
module stream_fifo2
  import stream_demux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  fifo2_state_t r_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         w_push;
  logic         w_pop;

  assign push_ready = (r_state != FULL);
  assign pop_valid  = (r_state != EMPTY);
  assign pop_data   = r_head;

  assign w_push = push_valid & push_ready;
  assign w_pop  = pop_valid & pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head  <= push_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          // push&pop replaces the head in place, keeping order
          if (w_push && w_pop) begin
            r_head <= push_data;
          end else if (w_push) begin
            r_tail  <= push_data;
            r_state <= FULL;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_buffered.sv
// 1-to-N valid/ready demux with a 2-entry FIFO per channel.
// Out-of-range selects are accepted, dropped and flagged in err_sel.
module stream_demux_buffered
  import stream_demux_pkg::*;
#(
  parameter  int W    = DEF_W,
  parameter  int N    = DEF_N,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [W-1:0]    up_data,
  input  logic [SELW-1:0] up_sel,
  output logic [N-1:0]    dn_valid,
  input  logic [N-1:0]    dn_ready,
  output logic [N*W-1:0]  dn_data,
  output logic            err_sel
);

  logic [N-1:0] w_push_valid;
  logic [N-1:0] w_push_ready;
  logic         w_sel_ok;
  logic         w_up_ready;
  logic         r_err_sel;

  assign w_sel_ok = ({1'b0, up_sel} < (SELW+1)'(N));

  always_comb begin
    w_push_valid = '0;
    w_up_ready   = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (up_sel == SELW'(k)) begin
        w_push_valid[k] = up_valid;
        w_up_ready      = w_push_ready[k];
      end
    end
  end

  assign up_ready = w_up_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sel <= 1'b0;
    end else if (up_valid && !w_sel_ok) begin
      r_err_sel <= 1'b1;
    end
  end

  assign err_sel = r_err_sel;

  for (genvar k = 0; k < N; k++) begin : g_ch
    stream_fifo2 #(.W(W)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (w_push_valid[k]),
      .push_ready (w_push_ready[k]),
      .push_data  (up_data),
      .pop_valid  (dn_valid[k]),
      .pop_ready  (dn_ready[k]),
      .pop_data   (dn_data[k*W +: W])
    );
  end

endmodule

// File: tb/tb_stream_demux_buffered.sv
// Bench for stream_demux_buffered: queue-based reference model,
// directed scenarios plus random traffic; second instance with N=3.
module tb_stream_demux_buffered;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [7:0]  up_data = '0;
  logic [1:0]  up_sel = '0;
  logic [3:0]  dn_valid;
  logic [3:0]  dn_ready = '0;
  logic [31:0] dn_data;
  logic        err_sel;

  logic        rst3_n = 1'b0;
  logic        u3_valid = 1'b0;
  logic        u3_ready;
  logic [7:0]  u3_data = '0;
  logic [1:0]  u3_sel = '0;
  logic [2:0]  d3_valid;
  logic [2:0]  d3_ready = 3'b111;
  logic [23:0] d3_data;
  logic        err3;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] mq [4][$];

  always #5 clk = ~clk;

  stream_demux_buffered #(.W(8), .N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_data  (up_data),
    .up_sel   (up_sel),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .dn_data  (dn_data),
    .err_sel  (err_sel)
  );

  stream_demux_buffered #(.W(8), .N(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst3_n),
    .up_valid (u3_valid),
    .up_ready (u3_ready),
    .up_data  (u3_data),
    .up_sel   (u3_sel),
    .dn_valid (d3_valid),
    .dn_ready (d3_ready),
    .dn_data  (d3_data),
    .err_sel  (err3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic v, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] r);
    logic exp_rdy;
    up_valid = v;
    up_sel   = s;
    up_data  = d;
    dn_ready = r;
    #1;
    exp_rdy = (mq[s].size() < 2);
    chk("up_ready", 32'(up_ready), 32'(exp_rdy));
    chk("err_sel", 32'(err_sel), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dn_valid%0d", k), 32'(dn_valid[k]),
          32'(mq[k].size() != 0));
      if (mq[k].size() != 0)
        chk($sformatf("dn_data%0d", k), 32'(dn_data[k*8 +: 8]),
            32'(mq[k][0]));
    end
    for (int k = 0; k < 4; k++)
      if (r[k] && mq[k].size() != 0) void'(mq[k].pop_front());
    if (v && exp_rdy) mq[s].push_back(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic peek_ready(input string tag, input logic [1:0] s,
                            input logic exp);
    up_valid = 1'b0;
    up_sel   = s;
    #1;
    chk(tag, 32'(up_ready), 32'(exp));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    #1;
    chk("rst_valid", 32'(dn_valid), 32'h0);
    chk("rst_data", dn_data, 32'h0);
    chk("rst_err", 32'(err_sel), 32'd0);
    for (int s = 0; s < 4; s++)
      peek_ready($sformatf("rst_ready%0d", s), 2'(s), 1'b1);
    @(negedge clk);

    // single word to ch2
    step(1'b1, 2'd2, 8'hA5, 4'hF);
    chk("t1_valid", 32'(dn_valid), 32'h4);
    chk("t1_data", 32'(dn_data[23:16]), 32'hA5);
    step(1'b0, 2'd0, 8'h00, 4'hF);

    // ch1 stalled, ch3 still flows
    step(1'b1, 2'd1, 8'h11, 4'b1101);
    step(1'b1, 2'd1, 8'h22, 4'b1101);
    peek_ready("t2_full", 2'd1, 1'b0);
    step(1'b1, 2'd3, 8'h33, 4'b1101);
    chk("t2_ch3", 32'(dn_data[31:24]), 32'h33);
    chk("t2_valid", 32'(dn_valid), 32'b1010);

    // drain ch1 in order
    step(1'b0, 2'd1, 8'h00, 4'hF);
    peek_ready("t3_ready", 2'd1, 1'b1);
    chk("t3_second", 32'(dn_data[15:8]), 32'h22);
    step(1'b0, 2'd1, 8'h00, 4'hF);
    chk("t3_empty", 32'(dn_valid), 32'h0);

    // round-robin streaming
    for (int i = 0; i < 16; i++)
      step(1'b1, 2'(i % 4), 8'(8'h40 + i), 4'hF);
    step(1'b0, 2'd0, 8'h00, 4'hF);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom), 4'($urandom));

    // reset mid-operation with ch0 full
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 8'h00, 4'hF);
    step(1'b1, 2'd0, 8'hC1, 4'b1110);
    step(1'b1, 2'd0, 8'hC2, 4'b1110);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(dn_valid), 32'h0);
    chk("t6_err", 32'(err_sel), 32'd0);
    for (int k = 0; k < 4; k++) mq[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd0, 8'hD1, 4'b1110);
    step(1'b1, 2'd0, 8'hD2, 4'b1110);
    chk("t6_new", 32'(dn_data[7:0]), 32'hD1);
    step(1'b0, 2'd0, 8'h00, 4'hF);
    step(1'b0, 2'd0, 8'h00, 4'hF);
    step(1'b0, 2'd0, 8'h00, 4'hF);

    // N=3: in-range word, then out-of-range select
    u3_valid = 1'b1;
    u3_sel   = 2'd2;
    u3_data  = 8'h5A;
    @(negedge clk);
    u3_valid = 1'b0;
    #1;
    chk("t5_inrange", 32'(d3_valid), 32'b100);
    chk("t5_data", 32'(d3_data[23:16]), 32'h5A);
    chk("t5_noerr", 32'(err3), 32'd0);
    @(negedge clk);
    u3_valid = 1'b1;
    u3_sel   = 2'd3;
    u3_data  = 8'hEE;
    #1;
    chk("t5_ready", 32'(u3_ready), 32'd1);
    @(negedge clk);
    u3_valid = 1'b0;
    #1;
    chk("t5_err", 32'(err3), 32'd1);
    chk("t5_drop", 32'(d3_valid), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("t5_sticky", 32'(err3), 32'd1);
    rst3_n = 1'b0;
    #1;
    chk("t5_clr", 32'(err3), 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
